user_input_conditioner: RTL and testbench
=========================================

# user_input_conditioner

Parametrised multi-channel conditioner for raw push-button and switch inputs. Each channel synchronises its asynchronous input, debounces it with a consecutive-sample counter, and emits a clean level plus single-cycle press, release and auto-repeat pulses. It sits between the board KEY/SW pins and the game/control FSMs, which consume only single-cycle event strobes.

## Interface
- CHANNELS, 4, number of independent input channels (≥1)
- DEBOUNCE_CYCLES, 4, consecutive cycles a new level must persist at synchroniser output before it is accepted (≥1)
- REPEAT_DELAY, 0, cycles from press pulse to first repeat pulse while held; 0 disables auto-repeat
- REPEAT_PERIOD, 1, cycles between subsequent repeat pulses (≥1; ignored when REPEAT_DELAY = 0)

- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- in  in  CHANNELS  raw inputs, 1 = pressed, asynchronous to Clock
- level  out  CHANNELS  debounced level per channel
- press  out  CHANNELS  one-cycle pulse on debounced 0→1
- release  out  CHANNELS  one-cycle pulse on debounced 1→0
- repeat  out  CHANNELS  one-cycle auto-repeat pulse while held
- any_press  out  1  OR of press (registered with press, same cycle)

## Operation
- Reset low: all flops (sync stages, level, counters, pulses) clear to 0 immediately, independent of Clock; all outputs 0. Released level is the reset state.
- Per channel, fully independent; no cross-channel interaction except any_press.
- Sync: two flops s1 ← in, s2 ← s1.
- Debounce: counter dcnt, width $clog2(DEBOUNCE_CYCLES)+1.
  - s2 == level: dcnt ← 0.
  - s2 != level and dcnt == DEBOUNCE_CYCLES−1: level ← s2, dcnt ← 0.
  - otherwise dcnt ← dcnt+1.
  - Any single agreeing sample restarts the count.
- Event pulses registered, set on the same edge level flips: press ← level 0→1, release ← level 1→0; each high exactly one cycle.
- Auto-repeat (REPEAT_DELAY > 0), down-counter rcnt:
  - on press edge load REPEAT_DELAY−1
  - while level = 1: rcnt = 0 → repeat pulse, reload REPEAT_PERIOD−1; else decrement
  - level 0 or release edge: rcnt ← 0, no repeat
  - repeat never coincides with press or release
- REPEAT_DELAY = 0: repeat tied 0, counter logic removed.
- States per channel: RELEASED (level 0), PRESSED_WAIT (level 1, before first repeat), REPEATING (level 1, periodic).

## Timing
- Edge numbering: in changes and is captured into s1 at edge 0.
- s2 updates at edge 1; level, press/release update at edge DEBOUNCE_CYCLES+1. Latency in→level = DEBOUNCE_CYCLES+1 edges (plus metastability cycle).
- Input pulse of DEBOUNCE_CYCLES cycles accepted; DEBOUNCE_CYCLES−1 cycles rejected. Same for release glitches.
- Press pulse at edge P → first repeat at edge P+REPEAT_DELAY, then P+REPEAT_DELAY+k·REPEAT_PERIOD.
- Input held pressed through reset deassertion: treated as new press; press fires DEBOUNCE_CYCLES+1 edges after first capture.
- Reset asserted mid-count or mid-pulse: pulse aborts, counts lost, no event emitted on release of reset unless input is pressed.
- Simultaneous events on different channels: all pulses in same cycle; any_press high one cycle.

## Test plan
- Clean press, DEBOUNCE_CYCLES=4: in[0] 0→1 before edge 0, held → level[0] and press[0] rise at edge 5, press[0] low at edge 6, any_press mirrors press[0]; release 40 cycles later → release[0] one cycle, 5 edges after change.
- Bounce rejection: in[1] high 3 cycles then low → level, press, release stay 0; high exactly 4 cycles → press then release each once.
- Auto-repeat, REPEAT_DELAY=8, REPEAT_PERIOD=3: hold in[2] from edge 0 → press at 5, repeat at 13, 16, 19, 22; drop input → release fires, no further repeat.
- Multi-channel: in[0] and in[3] rise same cycle → press[0] and press[3] same cycle, any_press single pulse; in[1] untouched stays 0.
- Reset mid-operation: Reset low at edge 3 of a press → all outputs 0 asynchronously; Reset high with in still 1 → press 5 edges after first post-reset capture.
- REPEAT_DELAY=0 build: hold 100 cycles → exactly one press, repeat constant 0.

Source files
------------

// File: rtl/user_input_conditioner.sv
// Purpose : per-channel sync + debounce of raw buttons/switches, emitting clean level and one-cycle press/release/repeat strobes.
// Latency : in -> level/press/release = DEBOUNCE_CYCLES+1 edges after first capture; any_press registered alongside press.
// Backpr. : none; free-running, outputs are strobes every consumer must take in the cycle they appear.
//
// Ports:
//   i_clk        system clock, all state on rising edge
//   i_rst_n      asynchronous active-low reset, clears every flop
//   i_in         raw inputs (1 = pressed), asynchronous to i_clk
//   o_level      debounced level per channel
//   o_press      one-cycle pulse on debounced 0->1
//   o_release    one-cycle pulse on debounced 1->0
//   o_repeat     one-cycle auto-repeat pulse while held (tied 0 when REPEAT_DELAY = 0)
//   o_any_press  OR of the press pulses, same cycle as o_press
module user_input_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [CHANNELS-1:0] i_in,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release,
    output logic [CHANNELS-1:0] o_repeat,
    output logic                o_any_press
);

    localparam int             DW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0]  DMAX = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESSED_WAIT = 2'd1,
        ST_REPEATING    = 2'd2
    } state_t;

    logic [CHANNELS-1:0] w_press_set;
    logic                r_any_press;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic          r_s1;
        logic          r_s2;
        logic [DW-1:0] r_dcnt;
        logic [DW-1:0] w_dcnt_nxt;
        state_t        r_state;
        state_t        w_state_nxt;
        logic          w_level;
        logic          w_flip;
        logic          w_rpt_hit;
        logic          r_press;
        logic          r_release;
        logic          r_repeat;

        // The debounced level is carried by the FSM state itself.
        assign w_level = (r_state != ST_RELEASED);
        // Level is about to change this edge: disagreement has persisted long enough.
        assign w_flip  = (r_s2 != w_level) && (r_dcnt == DMAX);
        assign w_press_set[g] = w_flip & ~w_level;

        always_comb begin
            w_dcnt_nxt = '0;
            if ((r_s2 != w_level) && !w_flip) begin
                w_dcnt_nxt = r_dcnt + 1'b1;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                ST_RELEASED: begin
                    if (w_flip) w_state_nxt = ST_PRESSED_WAIT;
                end
                ST_PRESSED_WAIT: begin
                    if (w_flip)         w_state_nxt = ST_RELEASED;
                    else if (w_rpt_hit) w_state_nxt = ST_REPEATING;
                end
                ST_REPEATING: begin
                    if (w_flip) w_state_nxt = ST_RELEASED;
                end
                default: w_state_nxt = ST_RELEASED;
            endcase
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_s1      <= 1'b0;
                r_s2      <= 1'b0;
                r_dcnt    <= '0;
                r_state   <= ST_RELEASED;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_repeat  <= 1'b0;
            end else begin
                r_s1      <= i_in[g];
                r_s2      <= r_s1;
                r_dcnt    <= w_dcnt_nxt;
                r_state   <= w_state_nxt;
                r_press   <= w_flip & ~w_level;
                r_release <= w_flip &  w_level;
                r_repeat  <= w_rpt_hit;
            end
        end

        if (REPEAT_DELAY > 0) begin : g_rpt
            localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
            logic [RW-1:0] r_rcnt;

            // Held and not releasing this edge: an expired count fires a repeat.
            // A press edge has w_level = 0, so repeat can never coincide with press.
            assign w_rpt_hit = w_level & ~w_flip & (r_rcnt == '0);

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_rcnt <= '0;
                end else if (w_flip && !w_level) begin
                    r_rcnt <= RW'(REPEAT_DELAY - 1);
                end else if (!w_level || w_flip) begin
                    r_rcnt <= '0;
                end else if (r_rcnt == '0) begin
                    r_rcnt <= RW'(REPEAT_PERIOD - 1);
                end else begin
                    r_rcnt <= r_rcnt - 1'b1;
                end
            end
        end else begin : g_norpt
            assign w_rpt_hit = 1'b0;
        end

        assign o_level[g]   = w_level;
        assign o_press[g]   = r_press;
        assign o_release[g] = r_release;
        assign o_repeat[g]  = r_repeat;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_any_press <= 1'b0;
        else          r_any_press <= |w_press_set;
    end

    assign o_any_press = r_any_press;

endmodule

// File: tb/tb_user_input_conditioner.sv
module tb_user_input_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_a;
    logic [3:0] level_a, press_a, rel_a, rpt_a;
    logic       any_a;
    logic [3:0] in_b;
    logic [3:0] level_b, press_b, rel_b, rpt_b;
    logic       any_b;

    int checks = 0;
    int errors = 0;

    user_input_conditioner #(
        .CHANNELS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in(in_a),
        .o_level(level_a), .o_press(press_a), .o_release(rel_a),
        .o_repeat(rpt_a), .o_any_press(any_a)
    );

    user_input_conditioner #(
        .CHANNELS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(1)
    ) dut_norpt (
        .i_clk(clk), .i_rst_n(rst_n), .i_in(in_b),
        .o_level(level_b), .o_press(press_b), .o_release(rel_b),
        .o_repeat(rpt_b), .o_any_press(any_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cnt_p, cnt_r, cnt_rep, cnt_any, seen;

        rst_n = 1'b0;
        in_a  = '0;
        in_b  = '0;

        // Reset state
        #2;
        check("rst_level", 0, level_a, 0);
        check("rst_press", 0, press_a, 0);
        check("rst_rel",   0, rel_a,   0);
        check("rst_rpt",   0, rpt_a,   0);
        check("rst_any",   0, any_a,   0);
        check("rst_levelb", 0, level_b, 0);
        edges(2);
        rst_n = 1'b1;
        edges(3);

        // Clean press / release on channel 0
        in_a = 4'b0001;
        for (int e = 0; e <= 6; e++) begin
            edges(1);
            check("t1_level", e, level_a[0], (e >= 5));
            check("t1_press", e, press_a[0], (e == 5));
            check("t1_any",   e, any_a,      (e == 5));
        end
        edges(40);
        in_a = 4'b0000;
        for (int e = 0; e <= 6; e++) begin
            edges(1);
            check("t1_rel",    e, rel_a[0],   (e == 5));
            check("t1_rlevel", e, level_a[0], (e < 5));
        end
        edges(4);

        // Bounce rejection: 3-cycle glitch on channel 1
        in_a[1] = 1'b1;
        edges(3);
        in_a[1] = 1'b0;
        seen = 0;
        for (int e = 0; e < 12; e++) begin
            edges(1);
            seen = seen | int'(level_a[1]) | int'(press_a[1]) | int'(rel_a[1]);
        end
        check("t2_glitch3", 0, seen, 0);

        // Exactly 4 cycles is accepted
        in_a[1] = 1'b1;
        edges(4);
        in_a[1] = 1'b0;
        cnt_p = 0; cnt_r = 0; cnt_rep = 0; seen = 0;
        for (int e = 0; e < 16; e++) begin
            edges(1);
            cnt_p   += int'(press_a[1]);
            cnt_r   += int'(rel_a[1]);
            cnt_rep += int'(rpt_a[1]);
            seen    += int'(level_a[1]);
        end
        check("t2_press4", 0, cnt_p, 1);
        check("t2_rel4",   0, cnt_r, 1);
        check("t2_lvl4",   0, seen,  4);
        check("t2_rpt4",   0, cnt_rep, 0);
        edges(3);

        // Auto-repeat on channel 2: press at 5, repeats at 13,16,19,22
        in_a[2] = 1'b1;
        for (int e = 0; e <= 23; e++) begin
            edges(1);
            check("t3_press", e, press_a[2], (e == 5));
            check("t3_rpt",   e, rpt_a[2],   (e == 13 || e == 16 || e == 19 || e == 22));
        end
        in_a[2] = 1'b0;
        for (int f = 0; f <= 12; f++) begin
            edges(1);
            check("t3_rpt_tail", f, rpt_a[2], (f == 1 || f == 4));
            check("t3_rel",      f, rel_a[2], (f == 5));
        end
        edges(3);

        // Multi-channel simultaneous press
        in_a = 4'b1001;
        cnt_any = 0;
        for (int e = 0; e <= 7; e++) begin
            edges(1);
            cnt_any += int'(any_a);
            check("t4_press", e, press_a, (e == 5) ? 4'b1001 : 4'b0000);
            check("t4_level", e, level_a, (e >= 5) ? 4'b1001 : 4'b0000);
        end
        check("t4_anycnt", 0, cnt_any, 1);
        in_a = 4'b0000;
        edges(12);

        // Reset mid-operation, input still held through deassertion
        in_a[0] = 1'b1;
        edges(6);
        check("t5_pre_press", 0, press_a[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_level", 0, level_a, 0);
        check("t5_async_press", 0, press_a, 0);
        check("t5_async_any",   0, any_a,   0);
        edges(2);
        check("t5_hold_level", 0, level_a, 0);
        rst_n = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            edges(1);
            check("t5_press", e, press_a[0], (e == 5));
            check("t5_level", e, level_a[0], (e >= 5));
        end
        in_a = 4'b0000;
        edges(10);

        // REPEAT_DELAY = 0 build: long hold gives exactly one press, never a repeat
        in_b[0] = 1'b1;
        cnt_p = 0; cnt_rep = 0;
        for (int e = 0; e < 100; e++) begin
            edges(1);
            cnt_p   += int'(press_b[0]);
            cnt_rep += int'(rpt_b != 4'b0000);
        end
        check("t6_press", 0, cnt_p, 1);
        check("t6_rpt",   0, cnt_rep, 0);
        check("t6_level", 0, level_b, 4'b0001);
        in_b = 4'b0000;
        edges(8);
        check("t6_released", 0, level_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
